// File: rtl/line_walker_pkg.sv
// Shared rasterizer definitions: coordinate width, walker state encoding and
// the width of the Bresenham error accumulator.
package line_walker_pkg;

  // Signed width of endpoint and pixel coordinates.
  localparam int COORD_W = 10;

  // Error accumulator width; holds 2*dmin - 2*dmaj .. 2*dmin without overflow.
  localparam int D_W = COORD_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } walk_state_t;

endpackage : line_walker_pkg

// File: rtl/line_setup.sv
// Combinational line setup: maps the registered endpoints onto a
// major-axis-increasing octant and derives the Bresenham step constants.
module line_setup #(
  parameter int COORD_W = line_walker_pkg::COORD_W
) (
  input  logic                      steep,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  output logic signed [COORD_W-1:0] maj_start,
  output logic signed [COORD_W-1:0] min_start,
  output logic        [COORD_W:0]   dmaj,
  output logic        [COORD_W:0]   dmin,
  output logic                      smin_neg,
  output logic signed [COORD_W+2:0] d0
);

  logic signed [COORD_W-1:0] maj_a;
  logic signed [COORD_W-1:0] min_a;
  logic signed [COORD_W-1:0] maj_b;
  logic signed [COORD_W-1:0] min_b;
  logic signed [COORD_W-1:0] maj_end;
  logic signed [COORD_W-1:0] min_end;
  logic                      swap_ends;
  logic signed [COORD_W:0]   maj_diff;
  logic signed [COORD_W:0]   min_diff;

  // Role swap for steep lines, endpoint swap so the major axis increases,
  // then deltas, minor step direction and the initial decision value.
  always_comb begin
    maj_a     = steep ? y0 : x0;
    min_a     = steep ? x0 : y0;
    maj_b     = steep ? y1 : x1;
    min_b     = steep ? x1 : y1;

    swap_ends = (maj_b < maj_a);
    maj_start = swap_ends ? maj_b : maj_a;
    min_start = swap_ends ? min_b : min_a;
    maj_end   = swap_ends ? maj_a : maj_b;
    min_end   = swap_ends ? min_a : min_b;

    // One extra bit of sign extension keeps full-range differences exact.
    maj_diff  = $signed({maj_end[COORD_W-1], maj_end})
              - $signed({maj_start[COORD_W-1], maj_start});
    min_diff  = $signed({min_end[COORD_W-1], min_end})
              - $signed({min_start[COORD_W-1], min_start});

    dmaj      = maj_diff;
    smin_neg  = min_diff[COORD_W];
    dmin      = smin_neg ? -min_diff : min_diff;

    d0        = $signed({1'b0, dmin, 1'b0}) - $signed({2'b00, dmaj});
  end

endmodule : line_setup

// File: rtl/line_walker.sv
// Line walker: accepts one segment per handshake, normalises it through
// line_setup, then steps it with an integer Bresenham accumulator emitting
// one pixel per accepted output beat.
module line_walker #(
  parameter int COORD_W = line_walker_pkg::COORD_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] pix_x,
  output logic signed [COORD_W-1:0] pix_y,
  output logic                      pix_last,
  output logic                      busy
);

  import line_walker_pkg::*;

  localparam int ERR_W = COORD_W + 3;

  walk_state_t state, state_nxt;

  // Registered request
  logic signed [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
  logic                      steep_r;

  // Walk state
  logic signed [COORD_W-1:0] maj_pos;
  logic signed [COORD_W-1:0] min_pos;
  logic        [COORD_W:0]   cnt;
  logic signed [ERR_W-1:0]   err;
  logic signed [ERR_W-1:0]   inc_axis;
  logic signed [ERR_W-1:0]   inc_diag;
  logic                      smin_neg_r;

  // Setup results
  logic signed [COORD_W-1:0] su_maj_start;
  logic signed [COORD_W-1:0] su_min_start;
  logic        [COORD_W:0]   su_dmaj;
  logic        [COORD_W:0]   su_dmin;
  logic                      su_smin_neg;
  logic signed [ERR_W-1:0]   su_d0;

  // Request-side steepness test and FSM strobes
  logic signed [COORD_W:0]   dx;
  logic signed [COORD_W:0]   dy;
  logic        [COORD_W:0]   adx;
  logic        [COORD_W:0]   ady;
  logic                      steep_in;
  logic                      load_in;
  logic                      load_setup;
  logic                      step;
  logic                      cnt_zero;
  logic                      err_pos;

  line_setup #(
    .COORD_W (COORD_W)
  ) u_setup (
    .steep     (steep_r),
    .x0        (x0_r),
    .y0        (y0_r),
    .x1        (x1_r),
    .y1        (y1_r),
    .maj_start (su_maj_start),
    .min_start (su_min_start),
    .dmaj      (su_dmaj),
    .dmin      (su_dmin),
    .smin_neg  (su_smin_neg),
    .d0        (su_d0)
  );

  // Absolute endpoint deltas of the incoming request decide steepness.
  always_comb begin
    dx       = $signed({x1[COORD_W-1], x1}) - $signed({x0[COORD_W-1], x0});
    dy       = $signed({y1[COORD_W-1], y1}) - $signed({y0[COORD_W-1], y0});
    adx      = dx[COORD_W] ? -dx : dx;
    ady      = dy[COORD_W] ? -dy : dy;
    steep_in = (ady > adx);
  end

  // State register; reset aborts any line in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, handshake strobes and pixel outputs.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    pix_x      = '0;
    pix_y      = '0;
    pix_last   = 1'b0;
    load_in    = 1'b0;
    load_setup = 1'b0;
    step       = 1'b0;
    cnt_zero   = (cnt == '0);

    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_in   = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        busy       = 1'b1;
        load_setup = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        pix_x     = steep_r ? min_pos : maj_pos;
        pix_y     = steep_r ? maj_pos : min_pos;
        pix_last  = cnt_zero;
        if (out_ready) begin
          if (cnt_zero) state_nxt = ST_IDLE;
          else          step      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strictly positive decision value selects the diagonal step.
  assign err_pos = !err[ERR_W-1] && (err != '0);

  // Request capture, setup load and per-pixel Bresenham stepping.
  // NOTE: datapath registers are reset as well; they are few and it keeps
  // every post-reset value deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r       <= '0;
      y0_r       <= '0;
      x1_r       <= '0;
      y1_r       <= '0;
      steep_r    <= 1'b0;
      maj_pos    <= '0;
      min_pos    <= '0;
      cnt        <= '0;
      err        <= '0;
      inc_axis   <= '0;
      inc_diag   <= '0;
      smin_neg_r <= 1'b0;
    end else begin
      if (load_in) begin
        x0_r    <= x0;
        y0_r    <= y0;
        x1_r    <= x1;
        y1_r    <= y1;
        steep_r <= steep_in;
      end
      if (load_setup) begin
        maj_pos    <= su_maj_start;
        min_pos    <= su_min_start;
        cnt        <= su_dmaj;
        err        <= su_d0;
        smin_neg_r <= su_smin_neg;
        inc_axis   <= $signed({1'b0, su_dmin, 1'b0});
        inc_diag   <= $signed({1'b0, su_dmin, 1'b0}) - $signed({1'b0, su_dmaj, 1'b0});
      end
      if (step) begin
        maj_pos <= maj_pos + COORD_W'(1);
        cnt     <= cnt - (COORD_W+1)'(1);
        if (err_pos) begin
          min_pos <= smin_neg_r ? (min_pos - COORD_W'(1)) : (min_pos + COORD_W'(1));
          err     <= err + inc_diag;
        end else begin
          err     <= err + inc_axis;
        end
      end
    end
  end

endmodule : line_walker

// File: tb/tb_line_walker.sv
// Self-checking bench for line_walker: directed octant cases, backpressure,
// reset mid-line and randomized segments against a closed-form line model.
module tb_line_walker;

  localparam int CW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [CW-1:0] pix_x, pix_y;
  logic                 pix_last;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic                 last;
  } pix_t;

  pix_t exp_q[$];

  line_walker #(.COORD_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  // Reference: the minor offset at major step i is the Bresenham rounding of
  // i*dmin/dmaj with exact halves rounded toward the start point.
  task automatic build_expected(input int ax0, input int ay0, input int ax1, input int ay1);
    int adx, ady, ma0, mi0, ma1, mi1, t, dmaj, dmin, s, off;
    bit steep;
    pix_t p;
    exp_q.delete();
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    steep = (ady > adx);
    ma0 = steep ? ay0 : ax0;  mi0 = steep ? ax0 : ay0;
    ma1 = steep ? ay1 : ax1;  mi1 = steep ? ax1 : ay1;
    if (ma1 < ma0) begin
      t = ma0; ma0 = ma1; ma1 = t;
      t = mi0; mi0 = mi1; mi1 = t;
    end
    dmaj = ma1 - ma0;
    dmin = (mi1 >= mi0) ? mi1 - mi0 : mi0 - mi1;
    s    = (mi1 >= mi0) ? 1 : -1;
    for (int i = 0; i <= dmaj; i++) begin
      off    = (dmaj == 0) ? 0 : (2 * i * dmin + dmaj - 1) / (2 * dmaj);
      p.x    = steep ? CW'(mi0 + s * off) : CW'(ma0 + i);
      p.y    = steep ? CW'(ma0 + i) : CW'(mi0 + s * off);
      p.last = (i == dmaj);
      exp_q.push_back(p);
    end
  endtask

  // Presents a segment, waits (bounded) for acceptance, checks the SETUP cycle.
  task automatic send_segment(input int ax0, input int ay0, input int ax1, input int ay1);
    int waited;
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL setup_cycle: out_valid=%b busy=%b in_ready=%b, expected 0 1 0",
               out_valid, busy, in_ready);
    end
  endtask

  // Consumes up to 'limit' pixels with random stalls in [lo,hi], checking
  // latency, throughput, hold-stability and values against exp_q.
  task automatic drain(input int stall_lo, input int stall_hi, input int limit,
                       input bit poke, input string tag);
    int n, waited, stalls;
    logic signed [CW-1:0] sx, sy;
    logic sl;
    n = (limit < exp_q.size()) ? limit : exp_q.size();
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!out_valid && waited < 8) begin
        @(posedge clk); #1; waited++;
      end
      n_vec++;
      if (!out_valid) begin
        n_err++;
        $display("FAIL %s timeout: pixel %0d out_valid=0 after %0d cycles, expected 1", tag, i, waited);
        out_ready = 1'b0;
        return;
      end
      n_vec++;
      if (i == 0 && waited != 1) begin
        n_err++;
        $display("FAIL %s latency: first out_valid %0d cycles after SETUP, expected 1", tag, waited);
      end else if (i > 0 && waited != 0) begin
        n_err++;
        $display("FAIL %s throughput: pixel %0d gap %0d cycles, expected 0", tag, i, waited);
      end
      stalls = $urandom_range(stall_hi, stall_lo);
      if (stalls > 0) begin
        out_ready = 1'b0;
        sx = pix_x; sy = pix_y; sl = pix_last;
        for (int s = 0; s < stalls; s++) begin
          if (poke) begin
            in_valid = 1'b1;
            x0 = CW'($urandom); y0 = CW'($urandom);
            x1 = CW'($urandom); y1 = CW'($urandom);
          end
          @(posedge clk); #1;
          n_vec++;
          if (out_valid !== 1'b1 || pix_x !== sx || pix_y !== sy || pix_last !== sl) begin
            n_err++;
            $display("FAIL %s hold: pixel %0d got v=%b (%0d,%0d) last=%b, expected v=1 (%0d,%0d) last=%b",
                     tag, i, out_valid, pix_x, pix_y, pix_last, sx, sy, sl);
          end
          if (poke) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
              n_err++;
              $display("FAIL %s in_ready_run: got %b, expected 0", tag, in_ready);
            end
          end
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      n_vec++;
      if (pix_x !== exp_q[i].x || pix_y !== exp_q[i].y || pix_last !== exp_q[i].last) begin
        n_err++;
        $display("FAIL %s pixel %0d: got (%0d,%0d) last=%b, expected (%0d,%0d) last=%b",
                 tag, i, pix_x, pix_y, pix_last, exp_q[i].x, exp_q[i].y, exp_q[i].last);
      end
      @(posedge clk); #1;
    end
    if (n == exp_q.size()) begin
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s end_of_line: out_valid=%b in_ready=%b busy=%b, expected 0 1 0",
                 tag, out_valid, in_ready, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int lo, input int hi, input bit poke, input string tag);
    build_expected(ax0, ay0, ax1, ay1);
    send_segment(ax0, ay0, ax1, ay1);
    drain(lo, hi, 1 << 30, poke, tag);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || pix_x !== '0 || pix_y !== '0 || pix_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: v=%b busy=%b pix=(%0d,%0d) last=%b, expected all 0",
               out_valid, busy, pix_x, pix_y, pix_last);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_octants;
    run_line( 0, 0,  3, 0, 0, 0, 1'b0, "horizontal");
    run_line( 0, 0,  4, 2, 0, 0, 1'b0, "shallow");
    run_line( 0, 0,  1, 3, 0, 0, 1'b0, "steep");
    run_line( 3, 0,  0, 0, 0, 0, 1'b0, "reversed");
    run_line(-2, 1,  0, 0, 0, 0, 1'b0, "negative");
    run_line( 3, 7, -4, -9, 0, 0, 1'b0, "steep_reversed");
  endtask

  task automatic test_degenerate;
    run_line(5, 5, 5, 5, 0, 0, 1'b0, "degenerate");
  endtask

  task automatic test_backpressure;
    run_line(0, 0, 4, 2, 3, 3, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid_line;
    build_expected(0, 0, 10, 0);
    send_segment(0, 0, 10, 0);
    drain(0, 0, 2, 1'b0, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_line: out_valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    run_line(0, 0, 1, 0, 0, 0, 1'b0, "post_reset");
  endtask

  task automatic test_extremes;
    run_line(-512, -512, 511,  511, 0, 0, 1'b0, "diag_full");
    run_line( 511, -512, -512, 511, 0, 1, 1'b0, "antidiag_full");
    run_line(-512,    0, 511,    1, 0, 0, 1'b0, "long_shallow");
    run_line(   0,  511,   1, -512, 0, 0, 1'b0, "long_steep");
  endtask

  task automatic test_back_to_back_random;
    int a, b, c, d;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) begin
        a = int'($urandom_range(40)) - 20; b = int'($urandom_range(40)) - 20;
        c = int'($urandom_range(40)) - 20; d = int'($urandom_range(40)) - 20;
      end else begin
        a = int'($urandom_range(1023)) - 512; b = int'($urandom_range(1023)) - 512;
        c = int'($urandom_range(1023)) - 512; d = int'($urandom_range(1023)) - 512;
      end
      run_line(a, b, c, d, 0, k % 3, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_octants;
    test_degenerate;
    test_backpressure;
    test_reset_mid_line;
    test_extremes;
    test_back_to_back_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_line_walker

// File: doc/line_walker.md
Name: line_walker

Overview:
Sequential line-setup and iteration stage. It sits directly upstream of the per-pixel point stepper and pixel writer in the rasterizer.
- Accepts one line segment (two endpoints) per handshake.
- Normalises the segment to a major-axis-increasing octant.
- Walks the segment with an integer Bresenham error accumulator.
- Emits one pixel coordinate per accepted output beat, with a last flag on the final pixel.

Parameters:
COORD_W, 10, signed coordinate width for endpoints and pixel outputs.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  segment request valid.
in_ready  out  1  block can accept a segment.
x0, y0  in  COORD_W  signed start point; sampled on in_valid&&in_ready.
x1, y1  in  COORD_W  signed end point; sampled on in_valid&&in_ready.
out_valid  out  1  pix_x/pix_y/pix_last valid.
out_ready  in  1  downstream accepts the pixel.
pix_x, pix_y  out  COORD_W  signed pixel coordinate.
pix_last  out  1  high on the final pixel of the segment.
busy  out  1  high in SETUP or RUN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, pix_x=0, pix_y=0, pix_last=0, busy=0, in_ready=1 once rst_n=1. Reset asserted mid-line aborts the line; no further pixels of that line are emitted.
- States: IDLE -> SETUP -> RUN -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: register endpoints and compute adx=|x1-x0|, ady=|y1-y0| (COORD_W+1 bits unsigned-safe).
  - steep = ady>adx.
  - Go to SETUP.
- SETUP (1 cycle, in_ready=0):
  - If steep, swap the x/y roles of both endpoints: major=y, minor=x.
  - If major_end < major_start, swap start/end endpoints. The pixel order then runs from the original end to the original start.
  - dmaj = major_end-major_start (>=0).
  - dmin = |minor_end-minor_start|.
  - smin = +1 if minor_end>=minor_start else -1.
  - D = 2*dmin - dmaj.
  - cnt = dmaj.
  - Load (maj,min) = start.
  - Go to RUN.
- RUN:
  - out_valid=1.
  - pix = steep ? (x=min, y=maj) : (x=maj, y=min).
  - pix_last = (cnt==0).
  - Outputs hold stable while out_valid&&!out_ready.
  - On out_valid&&out_ready with cnt!=0:
    - maj += 1; cnt -= 1.
    - If D>0: min += smin and D += 2*(dmin-dmaj).
    - Else (including D==0): D += 2*dmin.
  - On out_valid&&out_ready with cnt==0: out_valid=0, go to IDLE.
- Latency: input handshake in cycle N -> first out_valid in cycle N+2. Throughput is 1 pixel/cycle with out_ready=1. The next segment is accepted in the cycle after the last-pixel handshake (in_ready is combinational on state==IDLE).
- Pixel count = dmaj+1. A degenerate segment (x0==x1 and y0==y1) emits exactly one pixel with pix_last=1.
- Widths:
  - dmaj, dmin <= 2^COORD_W - 1, held in COORD_W+1 bits.
  - D held in COORD_W+3 bits signed; no overflow over the full range.
  - Pixel outputs always lie within the segment's bounding box, so no wrap.
- in_valid/endpoint changes outside IDLE are ignored.
- out_valid never drops without a handshake except on reset.

Decomposition:
- Shared rasterizer package holds:
  - COORD_W;
  - the state encoding enum (IDLE=0, SETUP=1, RUN=2);
  - the D width constant (COORD_W+3).
- One sub-module is natural: line_setup (combinational). It takes the registered endpoints and produces steep, start/end after swap, dmaj, dmin, smin and D0.
- The FSM, counters and stepping live in line_walker.

Test Plan:
- Horizontal (0,0)->(3,0), out_ready=1 -> (0,0),(1,0),(2,0),(3,0); pix_last only on (3,0); first out_valid 2 cycles after the in handshake.
- Shallow (0,0)->(4,2) -> (0,0),(1,0),(2,1),(3,1),(4,2).
- Steep (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3). Reversed (3,0)->(0,0) -> (0,0),(1,0),(2,0),(3,0).
- Negative and degenerate cases:
  - (-2,1)->(0,0) -> (-2,1),(-1,1),(0,0).
  - (5,5)->(5,5) -> single (5,5) with pix_last=1; in_ready returns the next cycle.
- Backpressure on (0,0)->(4,2): hold out_ready=0 for 3 cycles at each pixel -> outputs stable, same 5-pixel sequence, no drops or duplicates. in_valid pulsed during RUN is ignored.
- Reset mid-line: assert rst_n=0 asynchronously after the 2nd pixel of (0,0)->(10,0) -> out_valid=0 and busy=0 immediately. After release, in_ready=1, and a new segment (0,0)->(1,0) emits only (0,0),(1,0).
